// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, imem addressing, IF/ID register, issue counter
//
// Purpose:
//   Holds the fetch PC and presents its word address to the asynchronous
//   instruction memory. The returned instruction and its PC+4 are captured
//   into the IF/ID pipeline register on the next rising edge.
//   Also applies hazard stalls, ID-stage redirects and flushes, and counts
//   issued instructions with a saturating counter.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   stall          hold PC, IF/ID and issue_count this cycle
//   flush          load a bubble into IF/ID; PC still advances
//   redirect_valid taken branch/jump from ID
//   redirect_pc    byte target of the redirect
//   imem_addr      word address to instruction memory (combinational from pc)
//   imem_data      instruction returned by instruction memory
//   pc             current fetch PC (byte address)
//   ifid_instr     IF/ID instruction
//   ifid_pc4       IF/ID PC+4
//   ifid_valid     IF/ID holds a real instruction
//   misalign_err   one-cycle pulse after a redirect with nonzero low bits
//   issue_count    saturating count of valid IF/ID loads

module fetch_stage #(
    parameter int          ADDR_W   = 6,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] NOP      = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [31:0]       pc,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [31:0]       ifid_pc4,
    output logic              ifid_valid,
    output logic              misalign_err,
    output logic [31:0]       issue_count
);

    logic [31:0] pc_plus4;

    // Wraps modulo 2^32 naturally.
    assign pc_plus4  = pc + 32'd4;

    // Upper PC bits are dropped, so the memory aliases every 2^ADDR_W words.
    assign imem_addr = pc[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            ifid_instr   <= NOP[DATA_W-1:0];
            ifid_pc4     <= 32'h0;
            ifid_valid   <= 1'b0;
            misalign_err <= 1'b0;
            issue_count  <= 32'h0;
        end else if (stall) begin
            // Full freeze; any redirect or flush presented now is dropped.
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            pc           <= {redirect_pc[31:2], 2'b00};
            ifid_instr   <= NOP[DATA_W-1:0];
            ifid_pc4     <= 32'h0;
            ifid_valid   <= 1'b0;
            misalign_err <= |redirect_pc[1:0];
        end else if (flush) begin
            pc           <= pc_plus4;
            ifid_instr   <= NOP[DATA_W-1:0];
            ifid_pc4     <= 32'h0;
            ifid_valid   <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            pc           <= pc_plus4;
            ifid_instr   <= imem_data;
            ifid_pc4     <= pc_plus4;
            ifid_valid   <= 1'b1;
            misalign_err <= 1'b0;
            if (issue_count != 32'hFFFF_FFFF) begin
                issue_count <= issue_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              flush;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [31:0]       pc;
    logic [DATA_W-1:0] ifid_instr;
    logic [31:0]       ifid_pc4;
    logic              ifid_valid;
    logic              misalign_err;
    logic [31:0]       issue_count;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks;
    int n_fail;

    fetch_stage #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(32'h0),
        .NOP     (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .pc            (pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .misalign_err  (misalign_err),
        .issue_count   (issue_count)
    );

    // Asynchronous-read instruction memory model.
    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic fl,
                         input logic rv, input logic [31:0] rpc);
        reset          = rst;
        stall          = stl;
        flush          = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = 32'hC0DE_0000 + 32'(i);
        end

        // Reset for two cycles.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        tick;
        check("rst_pc",        pc,           32'h0);
        check("rst_valid",     32'(ifid_valid), 32'h0);
        check("rst_instr",     ifid_instr,   32'h0);
        check("rst_pc4",       ifid_pc4,     32'h0);
        check("rst_count",     issue_count,  32'h0);
        check("rst_misalign",  32'(misalign_err), 32'h0);
        check("rst_imem_addr", 32'(imem_addr), 32'h0);

        // Sequential fetch: A then B.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        check("seq1_instr",  ifid_instr, 32'hC0DE_0000);
        check("seq1_pc4",    ifid_pc4,   32'h4);
        check("seq1_valid",  32'(ifid_valid), 32'h1);
        check("seq1_addr",   32'(imem_addr), 32'h1);
        tick;
        check("seq2_instr",  ifid_instr, 32'hC0DE_0001);
        check("seq2_pc",     pc,         32'h8);
        check("seq2_count",  issue_count, 32'h2);

        // Stall two cycles at pc=8; a redirect offered meanwhile is ignored.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
        tick;
        tick;
        check("stall_pc",     pc,          32'h8);
        check("stall_instr",  ifid_instr,  32'hC0DE_0001);
        check("stall_count",  issue_count, 32'h2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        check("unstall_instr", ifid_instr,  32'hC0DE_0002);
        check("unstall_pc4",   ifid_pc4,    32'hC);
        check("unstall_count", issue_count, 32'h3);

        // Aligned redirect at pc=0xC to 0x20.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
        tick;
        check("redir_pc",       pc,          32'h20);
        check("redir_valid",    32'(ifid_valid), 32'h0);
        check("redir_instr",    ifid_instr,  32'h0);
        check("redir_pc4",      ifid_pc4,    32'h0);
        check("redir_misalign", 32'(misalign_err), 32'h0);
        check("redir_count",    issue_count, 32'h3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        check("after_redir_instr", ifid_instr, 32'hC0DE_0008);
        check("after_redir_pc4",   ifid_pc4,   32'h24);

        // Misaligned redirect: low bits dropped, one-cycle error pulse.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h22);
        tick;
        check("mis_pc",    pc, 32'h20);
        check("mis_pulse", 32'(misalign_err), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        check("mis_clear", 32'(misalign_err), 32'h0);
        check("mis_instr", ifid_instr, 32'hC0DE_0008);
        check("mis_count", issue_count, 32'h5);

        // Flush: bubble, PC still advances (0x24 -> 0x28).
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick;
        check("flush_pc",    pc, 32'h28);
        check("flush_valid", 32'(ifid_valid), 32'h0);
        check("flush_instr", ifid_instr, 32'h0);
        check("flush_count", issue_count, 32'h5);

        // Stall + redirect + flush: full hold, redirect lost.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h13);
        tick;
        check("all_pc",       pc, 32'h28);
        check("all_valid",    32'(ifid_valid), 32'h0);
        check("all_misalign", 32'(misalign_err), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        check("all_after_pc",    pc, 32'h2C);
        check("all_after_instr", ifid_instr, 32'hC0DE_000A);

        // Reset during redirect wins.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h30);
        tick;
        check("rstredir_pc",    pc, 32'h0);
        check("rstredir_valid", 32'(ifid_valid), 32'h0);
        check("rstredir_count", issue_count, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        check("rstredir_next_pc",    pc, 32'h4);
        check("rstredir_next_instr", ifid_instr, 32'hC0DE_0000);

        // PC wrap from 0xFFFF_FFFC.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick;
        check("wrap_pc",   pc, 32'hFFFF_FFFC);
        check("wrap_addr", 32'(imem_addr), 32'h3F);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        check("wrap_next_pc", pc, 32'h0);
        check("wrap_pc4",     ifid_pc4, 32'h0);
        check("wrap_instr",   ifid_instr, 32'hC0DE_003F);

        // Address aliasing: pc 0x100 -> word 0.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        tick;
        check("alias_addr", 32'(imem_addr), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick;
        check("alias_instr", ifid_instr, 32'hC0DE_0000);
        check("alias_pc4",   ifid_pc4,   32'h104);

        // Counter saturation from a preset value.
        @(negedge clk);
        force dut.issue_count = 32'hFFFF_FFFE;
        #1;
        release dut.issue_count;
        tick;
        check("sat_step", issue_count, 32'hFFFF_FFFF);
        tick;
        check("sat_hold", issue_count, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
